// File: rtl/dyser_input_port_if.sv
// Host/fabric handshake bundle for dyser_input_port: host valid/ready push side,
// fabric {valid, payload} word and credit-return pulse.
interface dyser_input_port_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH:0]   d_out;
  logic             c_in;

  // Environment side: drives the host offer and the credit return.
  modport master (
    output in_valid,
    output in_data,
    output c_in,
    input  in_ready,
    input  d_out
  );

  // Port side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  c_in,
    output in_ready,
    output d_out
  );
endinterface

// File: rtl/dyser_input_port.sv
// Credit-based DySER fabric input port: host valid/ready into a small FIFO, words sent
// as {valid, payload} only while holding a downstream credit. DYSER_INPORT_BYPASS_EN
// enables a 1-edge bypass of the empty FIFO.
module dyser_input_port #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     conf_en,
  dyser_input_port_if.slave        bus,
  output logic [3:0]               credit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     credit_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  localparam logic [3:0]    CreditMax = 4'(CREDITS);
  localparam logic [CW-1:0] CntFull   = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       credit_q, credit_d;
  logic             err_q, err_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH:0]   d_out_q, d_out_d;

  logic accept, push, pop, bypass, sent;

  // Ready depends only on registered occupancy plus the rst/conf_en levels, never on c_in.
  assign bus.in_ready = !rst && !conf_en && (cnt_q != CntFull);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = !conf_en && (state_q == StActive) && (credit_q != 4'd0);

`ifdef DYSER_INPORT_BYPASS_EN
  // Only an empty FIFO may be bypassed, so a buffered head always leaves first.
  assign bypass = accept && (state_q == StIdle) && (credit_q != 4'd0);
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;
  assign sent = pop || bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    credit_d = credit_q;
    err_d    = err_q;
    state_d  = state_q;
    d_out_d  = '0;

    if (conf_en) begin
      // Configuration flush: credit_err is deliberately preserved.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      credit_d = CreditMax;
      state_d  = StIdle;
    end else begin
      if (pop) begin
        d_out_d  = {1'b1, mem_q[rd_ptr_q]};
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else if (bypass) begin
        d_out_d = {1'b1, bus.in_data};
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntOne;
        2'b01:   cnt_d = cnt_q - CntOne;
        default: cnt_d = cnt_q;
      endcase

      if (push) begin
        state_d = StActive;
      end else if (pop && (cnt_q == CntOne)) begin
        state_d = StIdle;
      end

      if (bus.c_in && !sent) begin
        if (credit_q == CreditMax) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + 4'd1;
        end
      end else if (sent && !bus.c_in) begin
        credit_d = credit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= CreditMax;
      err_q    <= 1'b0;
      state_q  <= StIdle;
      d_out_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      state_q  <= state_d;
      d_out_q  <= d_out_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.d_out  = d_out_q;
  assign credit_cnt = credit_q;
  assign fifo_cnt   = cnt_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_dyser_input_port.sv
// Self-checking bench for dyser_input_port: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dyser_input_port;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       conf_en;
  logic [3:0] credit_cnt;
  logic [2:0] fifo_cnt;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  dyser_input_port_if #(.WIDTH(WIDTH)) bus ();

  dyser_input_port #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .CREDITS(CREDITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .conf_en   (conf_en),
    .bus       (bus),
    .credit_cnt(credit_cnt),
    .fifo_cnt  (fifo_cnt),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered words and an integer credit count.
  logic [WIDTH-1:0] mq[$];
  int               mcredit;
  logic             merr;
  logic [WIDTH:0]   mdout;
  bit               mok = 1'b0;

  always @(posedge clk) begin : model
    bit snd, acc, byp, went;
    if (rst) begin
      mq.delete();
      mcredit = CREDITS;
      merr    = 1'b0;
      mdout   = '0;
      mok     = 1'b1;
    end else if (conf_en) begin
      mq.delete();
      mcredit = CREDITS;
      mdout   = '0;
    end else begin
      snd = (mq.size() != 0) && (mcredit != 0);
      acc = bus.in_valid && (mq.size() != DEPTH);
`ifdef DYSER_INPORT_BYPASS_EN
      byp = acc && (mq.size() == 0) && (mcredit != 0);
`else
      byp = 1'b0;
`endif
      if (snd) mdout = {1'b1, mq.pop_front()};
      else if (byp) mdout = {1'b1, bus.in_data};
      else mdout = '0;
      if (acc && !byp) mq.push_back(bus.in_data);
      went = snd || byp;
      if (bus.c_in && !went) begin
        if (mcredit == CREDITS) merr = 1'b1;
        else mcredit++;
      end else if (went && !bus.c_in) begin
        mcredit--;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (mok) begin
      chk("d_out", 64'(bus.d_out), 64'(mdout));
      chk("credit_cnt", 64'(credit_cnt), 64'(mcredit));
      chk("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
      chk("credit_err", 64'(credit_err), 64'(merr));
      chk("in_ready", 64'(bus.in_ready), 64'(!rst && !conf_en && (mq.size() != DEPTH)));
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic c,
                       input logic cf, input logic r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.c_in     = c;
    conf_en      = cf;
    rst          = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push one word into an empty, credited port and expect it on d_out exactly once.
  task automatic push_expect(input string name, input logic [WIDTH-1:0] w);
    drive(1'b1, w, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifndef DYSER_INPORT_BYPASS_EN
    chk({name, "_early"}, 64'(bus.d_out), 64'd0);
    chk({name, "_fifo"}, 64'(fifo_cnt), 64'd1);
    tick();
`endif
    chk({name, "_out"}, 64'(bus.d_out), 64'({1'b1, w}));
    chk({name, "_credit"}, 64'(credit_cnt), 64'(CREDITS - 1));
    tick();
    chk({name, "_once"}, 64'(bus.d_out), 64'd0);
  endtask

  task automatic push_burst(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + WIDTH'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("reset_dout", 64'(bus.d_out), 64'd0);
    chk("reset_ready", 64'(bus.in_ready), 64'd0);
    chk("reset_credit", 64'(credit_cnt), 64'(CREDITS));
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Single word latency.
    push_expect("a5", 32'hA5);

    // Three back-to-back words exhaust both credits; one credit releases the third.
    do_reset();
    push_burst(3, 32'h1);
    tick();
    chk("hold_credit", 64'(credit_cnt), 64'd0);
    chk("hold_fifo", 64'(fifo_cnt), 64'd1);
    chk("hold_dout", 64'(bus.d_out), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("third_out", 64'(bus.d_out), 64'h1_0000_0003);
    chk("third_credit", 64'(credit_cnt), 64'd0);

    // Six words fill the FIFO; credits returned alongside sends keep the count constant.
    do_reset();
    push_burst(6, 32'h11);
    chk("full_fifo", 64'(fifo_cnt), 64'd4);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("refill_credit", 64'(credit_cnt), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_out", 64'(bus.d_out), 64'({1'b1, 32'h13 + 32'(i)}));
      chk("drain_credit", 64'(credit_cnt), 64'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();

    // Credit overflow is sticky through conf_en, cleared only by rst.
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ovf_credit", 64'(credit_cnt), 64'(CREDITS));
    chk("ovf_err", 64'(credit_err), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("ovf_err_conf", 64'(credit_err), 64'd1);
    do_reset();
    chk("ovf_err_rst", 64'(credit_err), 64'd0);

    // conf_en flush with three buffered words and no credit.
    push_burst(5, 32'h21);
    chk("pre_conf_fifo", 64'(fifo_cnt), 64'd3);
    chk("pre_conf_credit", 64'(credit_cnt), 64'd0);
    drive(1'b1, 32'hBAD, 1'b1, 1'b1, 1'b0);
    tick();
    chk("conf_fifo", 64'(fifo_cnt), 64'd0);
    chk("conf_credit", 64'(credit_cnt), 64'(CREDITS));
    chk("conf_dout", 64'(bus.d_out), 64'd0);
    chk("conf_ready", 64'(bus.in_ready), 64'd0);
    tick();
    push_expect("post_conf", 32'h7);
    tick();

    // rst mid-burst with two buffered words.
    do_reset();
    push_burst(4, 32'h31);
    chk("pre_rst_fifo", 64'(fifo_cnt), 64'd2);
    drive(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_dout", 64'(bus.d_out), 64'd0);
    chk("rst_fifo", 64'(fifo_cnt), 64'd0);
    chk("rst_credit", 64'(credit_cnt), 64'(CREDITS));
    tick();
    tick();
    chk("rst_no_stale", 64'(bus.d_out), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0));
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
